// File: rtl/axis_bram_reader_pkg.sv
// Shared constants and helpers for the BRAM-to-AXI-Stream reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: output FIFO depth, occupancy and pointer types, pointer-advance helper.
package axis_bram_reader_pkg;

  // Depth 3 covers the occupancy of one stalled head word plus the two reads
  // that can already be in flight when tready drops.
  localparam int FIFO_DEPTH = 3;
  localparam int FIFO_CNT_W = 2;

  typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;
  typedef logic [1:0]            fifo_ptr_t;

  // Pointer advance for a non-power-of-two ring.
  function automatic fifo_ptr_t fifo_ptr_next(input fifo_ptr_t p);
    return (p == fifo_ptr_t'(FIFO_DEPTH - 1)) ? fifo_ptr_t'(0) : p + fifo_ptr_t'(1);
  endfunction

endpackage

// File: rtl/axis_reader_fifo.sv
// 3-entry synchronous FIFO holding {tlast, data} words captured from BRAM.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: pop is ignored while empty; a push into a full FIFO is only taken with a pop.
// Ports: clk, rst (async, active-high), push/wdata, pop, rdata (head word), count (occupancy 0..3).
module axis_reader_fifo
  import axis_bram_reader_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output fifo_cnt_t        count
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  fifo_ptr_t        wr_ptr;
  fifo_ptr_t        rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != fifo_cnt_t'(0));
  assign do_push = push && ((count != fifo_cnt_t'(FIFO_DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= fifo_ptr_t'(0);
      rd_ptr <= fifo_ptr_t'(0);
      count  <= fifo_cnt_t'(0);
    end else begin
      if (do_push) wr_ptr <= fifo_ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= fifo_ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + fifo_cnt_t'(1);
        2'b01:   count <= count - fifo_cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: emptiness is defined by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // The head slot is never the write target unless a pop frees it, so the
  // head stays stable while the consumer stalls.
  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/axis_bram_reader.sv
// Reads BRAM addresses 0..L through port B and emits them as an AXI4-Stream with tlast on L.
// Latency: start edge E0 -> en in the next cycle -> rddata after E1 -> tvalid after E2; 1 word/cycle with tready high.
// Backpressure: reads are throttled so FIFO occupancy plus the in-flight read never exceeds 3; tready has no combinational path to BRAM.
// Ports: aclk/areset; cfg_data (last address L), start, busy, sts_data (next address);
//        m_axis_* stream master; bram_portb_* read port (clk/rst mirror aclk/areset).
module axis_bram_reader
  import axis_bram_reader_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10,
  parameter int CONTINUOUS       = 0
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_data,
  input  logic                        start,
  output logic                        busy,
  output logic [BRAM_ADDR_WIDTH-1:0]  sts_data,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        bram_portb_clk,
  output logic                        bram_portb_rst,
  output logic                        bram_portb_en,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_portb_rddata
);

  generate
    if (AXIS_TDATA_WIDTH != BRAM_DATA_WIDTH) begin : g_width_err
      $error("axis_bram_reader: AXIS_TDATA_WIDTH must equal BRAM_DATA_WIDTH");
    end
  endgenerate

  logic [BRAM_ADDR_WIDTH-1:0] last_addr;
  logic [BRAM_ADDR_WIDTH-1:0] addr;
  logic                       done_issuing;
  logic                       inflight;
  logic                       inflight_tag;
  fifo_cnt_t                  count;
  logic [2:0]                 occupancy;
  logic                       issue;
  logic                       pop;
  logic                       at_last;
  logic [BRAM_DATA_WIDTH:0]   head;

  assign bram_portb_clk = aclk;
  assign bram_portb_rst = areset;

  // Issue decision uses registered state only; the read in flight counts
  // against FIFO space because it lands one edge later regardless of tready.
  assign occupancy     = {1'b0, count} + {2'b00, inflight};
  assign issue         = busy && !done_issuing && (occupancy < 3'd3);
  assign at_last       = (addr == last_addr);
  assign bram_portb_en = issue;
  assign bram_portb_addr = addr;
  assign sts_data      = addr;

  assign m_axis_tvalid = (count != fifo_cnt_t'(0));
  assign m_axis_tdata  = head[AXIS_TDATA_WIDTH-1:0];
  assign m_axis_tlast  = head[BRAM_DATA_WIDTH];
  assign pop           = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      busy         <= 1'b0;
      done_issuing <= 1'b0;
      last_addr    <= '0;
      addr         <= '0;
      inflight     <= 1'b0;
      inflight_tag <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_tag <= at_last;

      if (!busy) begin
        if (start) begin
          busy         <= 1'b1;
          last_addr    <= cfg_data;
          addr         <= '0;
          done_issuing <= 1'b0;
        end
      end else begin
        if (issue) begin
          if (at_last) begin
            if (CONTINUOUS != 0) addr <= '0;
            else                 done_issuing <= 1'b1;
          end else begin
            addr <= addr + BRAM_ADDR_WIDTH'(1);
          end
        end
        // Every issued word is drained before busy drops, so nothing is
        // in flight when the next start is accepted.
        if ((CONTINUOUS == 0) && pop && m_axis_tlast) busy <= 1'b0;
      end
    end
  end

  axis_reader_fifo #(
    .WIDTH(BRAM_DATA_WIDTH + 1)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (inflight),
    .wdata ({inflight_tag, bram_portb_rddata}),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

endmodule
